// File: rtl/uart_tx_fsm_pkg.sv
// uart_tx_pkg: shared state encoding and line-level constants for the UART transmit path.
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: producer request, serializer handshake and line outputs of the frame sequencer.
interface uart_tx_fsm_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] P_DATA;
  logic DATA_VALID;
  logic PAR_EN;
  logic PAR_TYP;
  logic ser_data;
  logic ser_done;
  logic ser_en;
  logic TX_OUT;
  logic busy;
  logic frame_err;
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, TX_OUT, busy, frame_err
  );
  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, TX_OUT, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_fsm_parity.sv
// parity_calc: XOR-reduce of the data byte, inverted for odd parity.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_typ,
  output logic              o_par
);
  assign o_par = (^i_data) ^ (i_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART frame sequencer (start, data, optional parity, stop) driving an external serializer.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_fsm_if.slave  bus
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_tx, r_busy, r_ser_en, r_err;
  logic w_accept, w_last, w_err, w_tx, w_par_en, w_par;
  assign w_accept = (r_state == IDLE) && bus.DATA_VALID;
  // The last data bit sits on ser_data one cycle before the final DATA cycle, because TX_OUT is its registered copy.
  assign w_last = (r_state == DATA) && (r_cnt == CNT_W'(DATA_W - 2));
  assign w_err  = ((r_state == START) || (r_state == DATA)) && (bus.ser_done != w_last);
`ifdef UART_TX_PARITY_EN
  logic r_par_en, r_par, w_par_calc;
  parity_calc #(.DATA_W(DATA_W)) u_parity (
    .i_data (bus.P_DATA),
    .i_typ  (bus.PAR_TYP),
    .o_par  (w_par_calc)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
    end else if (w_accept) begin
      r_par_en <= bus.PAR_EN;
      r_par    <= w_par_calc;
    end
  end
  assign w_par_en = r_par_en;
  assign w_par    = r_par;
`else
  logic w_unused;
  assign w_unused = ^{bus.P_DATA, bus.PAR_EN, bus.PAR_TYP};
  assign w_par_en = 1'b0;
  assign w_par    = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.DATA_VALID ? START : IDLE;
      START:   w_next = DATA;
      DATA:    w_next = (r_cnt == CNT_W'(DATA_W - 1)) ? (w_par_en ? PARITY : STOP) : DATA;
      PARITY:  w_next = STOP;
      default: w_next = IDLE;
    endcase
    w_tx = (w_next == START)  ? START_BIT :
           (w_next == DATA)   ? bus.ser_data :
           (w_next == PARITY) ? w_par :
           (w_next == STOP)   ? STOP_BIT : IDLE_LINE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tx     <= IDLE_LINE;
      r_busy   <= 1'b0;
      r_ser_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (r_state == DATA) ? r_cnt + 1'b1 : '0;
      r_tx     <= w_tx;
      r_busy   <= (w_next != IDLE);
      r_ser_en <= w_accept;
      r_err    <= w_accept ? 1'b0 : (r_err | w_err);
    end
  end
  assign bus.ser_en    = r_ser_en;
  assign bus.TX_OUT    = r_tx;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_err;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed frame vectors plus hand-written reset, back-to-back and framing-error sequences.
module tb_uart_tx_fsm;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  uart_tx_fsm_if #(.DATA_W(8)) bus ();
  uart_tx_fsm #(.DATA_W(8), .CNT_W(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    int          done_at;
    int          len;
    logic [11:0] tx;
    logic        err;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " tx"}, bus.TX_OUT, 1'b1);
    chk({tag, " busy"}, bus.busy, 1'b0);
    chk({tag, " ser_en"}, bus.ser_en, 1'b0);
    chk({tag, " frame_err"}, bus.frame_err, 1'b0);
  endtask
  task automatic run_frame(input vec_t v, input string tag);
    @(negedge CLK);
    bus.P_DATA = v.data;
    bus.PAR_EN = v.par_en;
    bus.PAR_TYP = v.par_typ;
    bus.DATA_VALID = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      chk($sformatf("%s tx c%0d", tag, n), bus.TX_OUT, v.tx[n-1]);
      chk($sformatf("%s busy c%0d", tag, n), bus.busy, n <= v.len);
      chk($sformatf("%s ser_en c%0d", tag, n), bus.ser_en, n == 1);
      if (n == 1) chk($sformatf("%s err clr", tag), bus.frame_err, 1'b0);
      if (n == v.len + 1) chk($sformatf("%s err end", tag), bus.frame_err, v.err);
      bus.DATA_VALID = 1'b0;
      bus.P_DATA = ~v.data;
      bus.PAR_EN = ~v.par_en;
      bus.PAR_TYP = ~v.par_typ;
      bus.ser_data = (n <= 8) ? v.data[(n-1) & 7] : 1'b0;
      bus.ser_done = (n == v.done_at);
    end
  endtask
  initial begin
    logic [11:0] pat55;
    pat55 = 12'b1110_1010_1010;
    bus.P_DATA = 8'h00;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.ser_data = 1'b0;
    bus.ser_done = 1'b0;
    vecs[0]  = '{8'hB3, 1'b0, 1'b0, 8, 10, 12'b1111_0110_0110, 1'b0};
`ifdef UART_TX_PARITY_EN
    vecs[1]  = '{8'hB3, 1'b1, 1'b0, 8, 11, 12'b1111_0110_0110, 1'b0};
    vecs[2]  = '{8'hB3, 1'b1, 1'b1, 8, 11, 12'b1101_0110_0110, 1'b0};
    vecs[3]  = '{8'hFF, 1'b1, 1'b0, 8, 11, 12'b1101_1111_1110, 1'b0};
`else
    vecs[1]  = '{8'hB3, 1'b1, 1'b0, 8, 10, 12'b1111_0110_0110, 1'b0};
    vecs[2]  = '{8'hB3, 1'b1, 1'b1, 8, 10, 12'b1111_0110_0110, 1'b0};
    vecs[3]  = '{8'hFF, 1'b1, 1'b0, 8, 10, 12'b1111_1111_1110, 1'b0};
`endif
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 8, 10, 12'b1110_0000_0000, 1'b0};
    vecs[5]  = '{8'h55, 1'b0, 1'b0, 8, 10, 12'b1110_1010_1010, 1'b0};
    vecs[6]  = '{8'h01, 1'b0, 1'b0, 8, 10, 12'b1110_0000_0010, 1'b0};
    vecs[7]  = '{8'h80, 1'b0, 1'b0, 8, 10, 12'b1111_0000_0000, 1'b0};
    vecs[8]  = '{8'hB3, 1'b0, 1'b0, 7, 10, 12'b1111_0110_0110, 1'b1};
    vecs[9]  = '{8'h55, 1'b0, 1'b0, 8, 10, 12'b1110_1010_1010, 1'b0};
    vecs[10] = '{8'h80, 1'b0, 1'b0, 0, 10, 12'b1111_0000_0000, 1'b1};
    vecs[11] = '{8'h01, 1'b0, 1'b0, 8, 10, 12'b1110_0000_0010, 1'b0};
    repeat (2) @(negedge CLK);
    chk_idle("in reset");
    RST = 1'b0;
    @(negedge CLK);
    chk_idle("after reset");
    for (int i = 0; i < 12; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
    // DATA_VALID held: second frame must start right after a single IDLE cycle.
    @(negedge CLK);
    bus.P_DATA = 8'h55;
    bus.PAR_EN = 1'b0;
    bus.DATA_VALID = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      chk($sformatf("hold tx c%0d", n), bus.TX_OUT, (n == 12) ? 1'b0 : pat55[n-1]);
      chk($sformatf("hold busy c%0d", n), bus.busy, (n <= 10) || (n == 12));
      chk($sformatf("hold ser_en c%0d", n), bus.ser_en, (n == 1) || (n == 12));
      bus.ser_data = (n <= 8) ? pat55[n] : (n == 12) ? 1'b1 : 1'b0;
      bus.ser_done = (n == 8);
    end
    bus.DATA_VALID = 1'b0;
    @(negedge CLK);
    chk("hold2 tx bit0", bus.TX_OUT, 1'b1);
    chk("hold2 ser_en", bus.ser_en, 1'b0);
    bus.ser_data = 1'b0;
    bus.ser_done = 1'b1;
    @(negedge CLK);
    chk("early err mid data", bus.frame_err, 1'b1);
    chk("hold2 tx bit1", bus.TX_OUT, 1'b0);
    chk("hold2 busy", bus.busy, 1'b1);
    bus.ser_done = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk_idle("mid-data reset");
    RST = 1'b0;
    @(negedge CLK);
    chk_idle("post reset idle");
    run_frame(vecs[0], "after abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame sequencer for the UART transmit path. It accepts a parallel byte from the upstream producer and drives the external `serializer` via `ser_en`/`ser_done`. It builds the line frame (start bit, 8 data bits from `ser_data`, optional parity, stop bit) onto `TX_OUT`, and owns the `busy` handshake back to the producer.

## Interface
- `DATA_W`, 8: data bits per frame; must match serializer width.
- `CNT_W`, 3: bit-counter width, `$clog2(DATA_W)`.

Ports:
- `CLK` input 1: single clock; all logic on rising edge.
- `RST` input 1: reset, **synchronous, active-high**.
- `P_DATA` input `DATA_W`: byte to transmit; sampled only on accept.
- `DATA_VALID` input 1: producer request; one-cycle pulse or level.
- `PAR_EN` input 1: 1 = parity bit inserted; sampled on accept.
- `PAR_TYP` input 1: 0 = even, 1 = odd; sampled on accept.
- `ser_data` input 1: current serial bit from serializer, LSB first.
- `ser_done` input 1: serializer flag, high in the cycle its last bit is on `ser_data`.
- `ser_en` output 1: one-cycle load/start pulse to serializer.
- `TX_OUT` output 1: UART line; idles high.
- `busy` output 1: frame in progress; producer must not expect acceptance.
- `frame_err` output 1: sticky; set on `ser_done` mismatch, cleared on next accept.

## Operation
- States: IDLE, START, DATA, PARITY, STOP (encoding in package).
- IDLE:
  - `TX_OUT`=1, `busy`=0.
  - If `DATA_VALID`=1, accept the frame: latch `PAR_EN`/`PAR_TYP`, compute parity of `P_DATA`, clear `frame_err`, pulse `ser_en`. Next state is START.
- START: `TX_OUT`=0. Next state is DATA. Bit counter cleared to 0.
- DATA:
  - `TX_OUT`=`ser_data`. Counter increments each cycle.
  - Counter is authoritative: on count `DATA_W-1`, leave DATA. Go to PARITY if latched `PAR_EN`, else STOP.
  - `ser_done` not high exactly in that cycle (early or missing) sets `frame_err`. Frame still completes normally.
- PARITY: `TX_OUT` = latched parity bit; even → XOR of data, odd → inverted XOR. Next state is STOP.
- STOP: `TX_OUT`=1. Next state is IDLE. `DATA_VALID` is ignored in STOP.
- `DATA_VALID` is ignored in any state other than IDLE. Changes to `P_DATA`/`PAR_*` mid-frame have no effect.

## Timing
- Reset (applied any cycle, including mid-frame): next edge gives IDLE, `TX_OUT`=1, `busy`=0, `ser_en`=0, `frame_err`=0, counter=0. Serializer is reset by the same `RST`.
- Accept edge T: `ser_en`=1 during cycle T+1 only; START in cycle T+1.
- Data bits occupy T+2..T+9. Parity (if enabled) at T+10. Stop at T+10 or T+11.
- `busy`=1 from T+1 through the stop cycle inclusive. It is registered; no combinational path from `DATA_VALID`.
- Frame length is 10 (no parity) or 11 cycles. Minimum accept-to-accept spacing is 11/12 cycles, because at least one IDLE cycle follows every STOP.
- `TX_OUT` and `busy` are registered. `TX_OUT` in DATA is a registered copy of `ser_data`. The serializer contract therefore puts bit *i* on `ser_data` in cycle T+1+i.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state, `parity_calc` instance and `PAR_EN`/`PAR_TYP` logic are compiled in, as described above.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and parity logic are removed. `PAR_EN`/`PAR_TYP` ports remain but are ignored.
  - DATA → STOP always; frame length is 10 cycles.

## Structure
- Package `uart_tx_pkg` holds:
  - State enum/localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - `START_BIT`=0, `STOP_BIT`=1, `IDLE_LINE`=1.
  - `PAR_EVEN`=0, `PAR_ODD`=1.
- Sub-module `parity_calc`: combinational XOR-reduce of `DATA_W` bits plus type select. It is instantiated only under `UART_TX_PARITY_EN`.

## Test plan
- Reset held 2 cycles then released → `TX_OUT`=1, `busy`=0, `ser_en`=0, `frame_err`=0. Reset pulsed mid-DATA gives the same values next cycle.
- `P_DATA`=0xB3, `PAR_EN`=0, `DATA_VALID` 1 cycle → `TX_OUT` sequence 0,1,1,0,0,1,1,0,1,1. `busy` high for 10 cycles. Single `ser_en` pulse.
- `P_DATA`=0xB3, `PAR_EN`=1, `PAR_TYP`=0 → parity bit 1 in cycle T+10, stop at T+11. With `PAR_TYP`=1, parity bit 0.
- `DATA_VALID` held high continuously with 0x55 → frames separated by exactly one IDLE cycle. No second `ser_en` while `busy`.
- Serializer model raising `ser_done` one cycle early → `frame_err`=1 after DATA. Frame length unchanged. Error cleared on next accept.
- Build without `UART_TX_PARITY_EN`, `PAR_EN`=1, 0xFF → 10-cycle frame 0,1×8,1. No parity bit.
